// File: rtl/mux2_bist.sv
// mux2_bist: W-bit registered 2:1 select stage (z = c ? b : a) with a
// built-in exhaustive self-test engine.
//
// The functional inputs and the BIST vector counter both feed the same
// core register. That means BIST exercises the real datapath, not a copy.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   a_in, b_in, c_in        functional operands and select
//   valid_in / valid_out    functional qualifier, delayed by one cycle
//   z_out                   core register output (bit 0 XOR inject_fault)
//   start                   launches a BIST run from IDLE or DONE
//   inject_fault            inverts z bit 0 at the core output
//   busy, done, pass        BIST status
//   fail_count              number of mismatching vectors
//   first_fail_vec          first failing {c, b, a}
//
// state | meaning
// IDLE  | functional mode, no results yet
// RUN   | one vector registered into the core per cycle
// DRAIN | final compare of vector N-1
// DONE  | functional mode, BIST results held
module mux2_bist #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      a_in,
    input  logic [W-1:0]      b_in,
    input  logic              c_in,
    input  logic              valid_in,
    output logic [W-1:0]      z_out,
    output logic              valid_out,
    input  logic              start,
    input  logic              inject_fault,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2*W+1:0]    fail_count,
    output logic [2*W:0]      first_fail_vec
);

    localparam int VW = 2 * W + 1;
    localparam int CW = 2 * W + 2;
    localparam logic [VW-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   core_q;
    logic           valid_q;
    logic [VW-1:0]  vec_q;
    logic [VW-1:0]  vec_dly_q;
    logic           chk_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic [CW-1:0]  fail_q;
    logic [VW-1:0]  ffv_q;

    logic [W-1:0]   fault_mask;
    logic [W-1:0]   z_q;
    logic           func_mode;
    logic           start_acc;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_c;
    logic [W-1:0]   core_d;
    logic [W-1:0]   golden;
    logic           mismatch;
    logic [CW-1:0]  fail_d;
    logic [VW-1:0]  ffv_d;

    always_comb begin
        fault_mask    = '0;
        fault_mask[0] = inject_fault;
    end

    assign z_q       = core_q ^ fault_mask;
    assign func_mode = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_acc = start && func_mode;

    // DRAIN keeps feeding the (held) vector. That way the functional inputs
    // cannot reach the core until the FSM is back in a functional state.
    always_comb begin
        if (func_mode) begin
            sel_a = a_in;
            sel_b = b_in;
            sel_c = c_in;
        end else begin
            sel_a = vec_q[W-1:0];
            sel_b = vec_q[2*W-1:W];
            sel_c = vec_q[2*W];
        end
        core_d = sel_c ? sel_b : sel_a;
    end

    // The golden value uses the sum-of-products form. It is written
    // independently of the core mux, so a fault in one is not mirrored in
    // the other.
    always_comb begin
        golden = ({W{vec_dly_q[2*W]}} & vec_dly_q[2*W-1:W])
               | (vec_dly_q[W-1:0] & ~{W{vec_dly_q[2*W]}});
    end

    assign mismatch = chk_q && (z_q != golden);

    always_comb begin
        fail_d = fail_q;
        ffv_d  = ffv_q;
        if (start_acc) begin
            fail_d = '0;
            ffv_d  = '0;
        end else if (mismatch) begin
            fail_d = fail_q + CW'(1);
            if (fail_q == '0) begin
                ffv_d = vec_dly_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            core_q    <= '0;
            valid_q   <= 1'b0;
            vec_q     <= '0;
            vec_dly_q <= '0;
            chk_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            ffv_q     <= '0;
        end else begin
            core_q    <= core_d;
            valid_q   <= valid_in && func_mode;
            vec_dly_q <= vec_q;
            chk_q     <= (state_q == S_RUN);
            fail_q    <= fail_d;
            ffv_q     <= ffv_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        vec_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (vec_q == VEC_LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        vec_q <= vec_q + VW'(1);
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (fail_d == '0);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign z_out          = z_q;
    assign valid_out      = valid_q && !busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_mux2_bist.sv
module tb_mux2_bist;

    localparam int W  = 2;
    localparam int VW = 2 * W + 1;
    localparam int CW = 2 * W + 2;
    localparam int N  = 1 << VW;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           c_in;
    logic           valid_in;
    logic [W-1:0]   z_out;
    logic           valid_out;
    logic           start;
    logic           inject_fault;
    logic           busy;
    logic           done;
    logic           pass;
    logic [CW-1:0]  fail_count;
    logic [VW-1:0]  first_fail_vec;

    int applied;
    int miscompares;

    typedef struct {
        logic [W-1:0] z;
        logic         v;
    } fexp_t;

    typedef struct {
        int            busy_cyc;
        logic [CW-1:0] fc;
        logic [VW-1:0] ffv;
        logic          pass;
    } bexp_t;

    fexp_t fq[$];
    bexp_t bq[$];

    mux2_bist #(.W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_in           (a_in),
        .b_in           (b_in),
        .c_in           (c_in),
        .valid_in       (valid_in),
        .z_out          (z_out),
        .valid_out      (valid_out),
        .start          (start),
        .inject_fault   (inject_fault),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_vec (first_fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_mux(logic [W-1:0] a, logic [W-1:0] b, logic c);
        return c ? b : a;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_in = 2'b11; b_in = 2'b10; c_in = 1'b1; valid_in = 1'b1;
        start = 1'b1; inject_fault = 1'b0;
        repeat (3) @(negedge clk);
        applied++; if (z_out !== '0) begin miscompares++; $display("FAIL reset_z got %0h want 0", z_out); end
        applied++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", valid_out); end
        applied++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        applied++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
        applied++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass got %0b want 0", pass); end
        applied++; if (fail_count !== '0) begin miscompares++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
        applied++; if (first_fail_vec !== '0) begin miscompares++; $display("FAIL reset_ffv got %0d want 0", first_fail_vec); end
        start = 1'b0;
        valid_in = 1'b0;
        rst_n = 1'b1;
    endtask

    // Drives directed vectors followed by random ones. Each result is
    // checked one cycle later against the scoreboard.
    task automatic test_functional(input int n_rand);
        logic [W-1:0] da [2] = '{2'b01, 2'b01};
        logic [W-1:0] db [2] = '{2'b10, 2'b10};
        logic         dc [2] = '{1'b1, 1'b0};
        fexp_t e;
        fexp_t g;
        for (int i = 0; i < 2 + n_rand + 1; i++) begin
            @(negedge clk);
            if (fq.size() != 0) begin
                e = fq.pop_front();
                applied++;
                if (z_out !== e.z) begin miscompares++; $display("FAIL func_z got %0h want %0h", z_out, e.z); end
                applied++;
                if (valid_out !== e.v) begin miscompares++; $display("FAIL func_valid got %0b want %0b", valid_out, e.v); end
            end
            if (i < 2) begin
                a_in = da[i]; b_in = db[i]; c_in = dc[i]; valid_in = 1'b1;
            end else begin
                a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom); valid_in = 1'($urandom);
            end
            if (i < 2 + n_rand) begin
                g.z = ref_mux(a_in, b_in, c_in);
                g.v = valid_in;
                fq.push_back(g);
            end
        end
        valid_in = 1'b0;
    endtask

    // Runs one BIST pass. The expectation is pushed at launch and checked
    // once busy falls. fault_all holds inject_fault high throughout.
    // fault_vec >= 0 raises it only in the cycle where that vector is
    // compared. start_mid >= 0 re-pulses start in that RUN cycle.
    task automatic run_bist(input logic fault_all, input int fault_vec, input int start_mid);
        bexp_t e;
        int    busy_cyc;
        bit    ended;
        e.busy_cyc = N + 1;
        if (fault_all) begin
            e.fc = CW'(N); e.ffv = '0; e.pass = 1'b0;
        end else if (fault_vec >= 0) begin
            e.fc = CW'(1); e.ffv = VW'(fault_vec); e.pass = 1'b0;
        end else begin
            e.fc = '0; e.ffv = '0; e.pass = 1'b1;
        end
        bq.push_back(e);
        @(negedge clk);
        inject_fault = fault_all;
        valid_in = 1'b1;
        start = 1'b1;
        busy_cyc = 0;
        ended = 1'b0;
        for (int c = 0; c < N + 20 && !ended; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            else ended = 1'b1;
            if (c == 5) begin
                applied++;
                if (valid_out !== 1'b0) begin miscompares++; $display("FAIL bist_valid_mask got %0b want 0", valid_out); end
            end
            start = (c == start_mid);
            inject_fault = fault_all || (fault_vec >= 0 && c == fault_vec + 1);
        end
        start = 1'b0;
        inject_fault = 1'b0;
        valid_in = 1'b0;
        e = bq.pop_front();
        applied++;
        if (!ended) begin miscompares++; $display("FAIL bist_timeout busy still high after %0d cycles", busy_cyc); end
        applied++;
        if (busy_cyc != e.busy_cyc) begin miscompares++; $display("FAIL bist_busy_cycles got %0d want %0d", busy_cyc, e.busy_cyc); end
        applied++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL bist_done got %0b want 1", done); end
        applied++;
        if (pass !== e.pass) begin miscompares++; $display("FAIL bist_pass got %0b want %0b", pass, e.pass); end
        applied++;
        if (fail_count !== e.fc) begin miscompares++; $display("FAIL bist_fail_count got %0d want %0d", fail_count, e.fc); end
        applied++;
        if (first_fail_vec !== e.ffv) begin miscompares++; $display("FAIL bist_ffv got %0d want %0d", first_fail_vec, e.ffv); end
    endtask

    task automatic test_clean_bist();
        run_bist(1'b0, -1, -1);
    endtask

    task automatic test_fault_bist();
        run_bist(1'b1, -1, -1);
    endtask

    task automatic test_partial_fault();
        run_bist(1'b0, 20, -1);
    endtask

    task automatic test_start_ignored();
        run_bist(1'b0, -1, 7);
    endtask

    // In DONE after a fault run, functional mode works and the results hold.
    // A restart then clears them and a clean pass follows.
    task automatic test_done_restart();
        run_bist(1'b1, -1, -1);
        test_functional(3);
        applied++;
        if (fail_count !== CW'(N)) begin miscompares++; $display("FAIL done_hold_fail_count got %0d want %0d", fail_count, N); end
        applied++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL done_hold_done got %0b want 1", done); end
        run_bist(1'b0, -1, -1);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        inject_fault = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        applied++;
        if (fail_count === '0) begin miscompares++; $display("FAIL midrun_pre_fail_count got 0 want nonzero"); end
        rst_n = 1'b0;
        inject_fault = 1'b0;
        #1;
        applied++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrun_busy got %0b want 0", busy); end
        applied++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrun_done got %0b want 0", done); end
        applied++; if (fail_count !== '0) begin miscompares++; $display("FAIL midrun_fail_count got %0d want 0", fail_count); end
        @(negedge clk);
        rst_n = 1'b1;
        run_bist(1'b0, -1, -1);
    endtask

    initial begin
        applied = 0;
        miscompares = 0;
        test_reset();
        test_functional(10);
        test_clean_bist();
        test_fault_bist();
        test_partial_fault();
        test_start_ignored();
        test_done_restart();
        test_reset_mid_run();
        test_functional(4);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2_bist.md
# mux2_bist

Parametrised W-bit 2:1 select datapath (z = c ? b : a, per bit z[i] = (c & b[i]) | (a[i] & ~c)) with a built-in exhaustive self-test engine. In functional mode it is a one-cycle registered mux. In BIST mode an internal FSM applies every {c, b, a} combination to the same registered core and checks each result against a golden expression. It counts mismatches and records the first failing vector. It sits in the lab datapath as the select stage and lets the silicon check itself without an external bench.

## Interface
- W, 4, data width of a, b and z; legal range 1..8
- N (derived), 2^(2W+1), number of BIST vectors
- CW (derived), 2W+2, width of the fail counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_in  in  W  functional operand a
- b_in  in  W  functional operand b
- c_in  in  1  functional select
- valid_in  in  1  functional input qualifier
- z_out  out  W  registered core output
- valid_out  out  1  z_out holds a functional result
- start  in  1  one-cycle pulse; launches BIST from IDLE or DONE
- inject_fault  in  1  when high, inverts z bit 0 at the core output (fault-path test)
- busy  out  1  BIST in RUN or DRAIN
- done  out  1  BIST complete; held until the next start
- pass  out  1  done & (fail_count == 0)
- fail_count  out  CW  number of mismatching vectors
- first_fail_vec  out  2W+1  first failing vector {c, b, a}; valid when fail_count != 0

## Operation
- One clock. Reset is asynchronous and active-low.
- Reset values: z_out=0, valid_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=0, FSM=IDLE, vector counter=0.
- Core register: on every edge it captures the W-bit mux result of its selected inputs. It is XORed with {0…0, inject_fault} before it drives z_out and the checker.
- Input select: functional inputs in IDLE/DONE. Vector counter in RUN. Vector bit mapping: [W-1:0]=a, [2W-1:W]=b, [2W]=c.
- FSM states:
  - IDLE: functional mode.
  - start → RUN. This clears fail_count, first_fail_vec and done, and sets the vector counter to 0.
  - RUN: each edge registers the current vector into the core and increments the counter. After vector N-1 is registered → DRAIN.
  - DRAIN: one cycle, for the final compare → DONE.
  - DONE: functional mode, with results held. start → RUN, with the same clearing as from IDLE.
- start is ignored in RUN/DRAIN.
- Checker: one cycle after a vector is registered, it compares z_out with the golden value computed from a one-cycle-delayed copy of the vector.
  - On mismatch, fail_count increments. Its maximum is N, so it cannot wrap at CW bits.
  - If this is the first mismatch since start, first_fail_vec captures the delayed vector.
- Functional path: valid_out is valid_in delayed by one cycle. valid_out is forced to 0 while busy. Functional inputs are ignored in RUN/DRAIN.
- Vector counter width is 2W+1. It does not wrap during RUN: the FSM leaves RUN on the edge that registers vector N-1.
- If rst_n is asserted mid-BIST, everything returns to reset values immediately. No partial results are retained.

## Timing
- Functional latency: 1 cycle, from valid_in/inputs to z_out/valid_out.
- BIST timeline, with start sampled at edge E0:
  - FSM=RUN after E0.
  - Vector k is registered at edge E(k+1) and compared at edge E(k+2).
  - DRAIN after edge E(N).
  - DONE after edge E(N+1).
- busy is high for exactly N+1 cycles. done and pass update at edge E(N+1).
- fail_count and first_fail_vec are final at E(N+1). They may change during RUN/DRAIN.
- start and inject_fault are sampled synchronously. inject_fault may toggle mid-run; it affects only the vectors whose outputs appear while it is high.

## Test plan
- Reset/functional, W=2: release rst_n, drive valid_in=1, a=01, b=10, c=1 → next cycle z_out=10, valid_out=1. With c=0 → z_out=01. All outputs are 0 during reset.
- Clean BIST, W=2 (N=32): pulse start → busy high for 33 cycles; done=1, pass=1, fail_count=0.
- Fault BIST, W=2: hold inject_fault=1 throughout and pulse start → fail_count=32, first_fail_vec=5'b00000, pass=0, done=1.
- Partial fault: raise inject_fault only during the cycle in which vector 20's result is compared → fail_count=1, first_fail_vec=20.
- Restart and ignore: pulse start mid-RUN → no effect, busy still 33 cycles. In DONE after a fault run, start → counts clear, then a clean run gives pass=1.
- Reset mid-run: drop rst_n at vector 10 → busy=0, done=0, fail_count=0 immediately. Release rst_n and pulse start → a full 33-cycle run.
